// File: rtl/lcd_pkg.sv
// Shared constants, state encodings and helpers for the HD44780 text driver.
package lcd_pkg;

  localparam int CNT_W = 20;

  localparam logic [7:0] CMD_FUNC  = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
  localparam logic [7:0] CMD_DISP  = 8'h0C;  // display on, cursor off
  localparam logic [7:0] CMD_ENTRY = 8'h06;  // increment, no shift
  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [7:0] CMD_LINE1 = 8'h80;  // DDRAM address 0x00
  localparam logic [7:0] CMD_LINE2 = 8'hC0;  // DDRAM address 0x40
  localparam logic [7:0] SPACE     = 8'h20;

  typedef enum logic [2:0] {
    ST_PWRON, ST_INIT, ST_ADDR1, ST_LINE1, ST_ADDR2, ST_LINE2
  } top_state_e;

  typedef enum logic [2:0] {
    PH_IDLE, PH_DELAY, PH_FETCH, PH_STROBE, PH_HOLD
  } byte_phase_e;

  // Non-printable characters would show as CGRAM glyphs; blank them instead.
  function automatic logic [7:0] printable(logic [7:0] c);
    return (c < 8'h20 || c > 8'h7E) ? SPACE : c;
  endfunction

  function automatic logic [7:0] init_cmd(logic [1:0] step);
    case (step)
      2'd0:    return CMD_FUNC;
      2'd1:    return CMD_DISP;
      2'd2:    return CMD_ENTRY;
      default: return CMD_CLEAR;
    endcase
  endfunction

endpackage

// File: rtl/lcd_text_driver_byte_writer.sv
// Drives one LCD bus transfer (FETCH/STROBE/HOLD) and owns the single shared
// down-counter, which also times the power-on delay.
module lcd_byte_writer
  import lcd_pkg::*;
#(
  parameter int POWERON_CYC    = 750000,
  parameter int E_PULSE_CYC    = 25,
  parameter int CMD_WAIT_CYC   = 2500,
  parameter int CLEAR_WAIT_CYC = 100000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       pwron_i,
  input  logic       start_i,
  input  logic       is_data_i,
  input  logic       long_wait_i,
  input  logic [7:0] byte_i,
  input  logic [7:0] char_i,
  output logic       done_o,
  output logic       rs_o,
  output logic       e_o,
  output logic [7:0] data_o
);

  if (POWERON_CYC < 2 || POWERON_CYC >= (1 << CNT_W) ||
      E_PULSE_CYC < 1 || E_PULSE_CYC >= (1 << CNT_W) ||
      CMD_WAIT_CYC < 1 || CMD_WAIT_CYC >= (1 << CNT_W) ||
      CLEAR_WAIT_CYC < 1 || CLEAR_WAIT_CYC >= (1 << CNT_W)) begin : g_param_chk
    $error("lcd_byte_writer: timing parameter out of range");
  end

  // One load cycle is spent leaving IDLE, one more on the done cycle, so the
  // first FETCH starts exactly POWERON_CYC edges after reset release.
  localparam logic [CNT_W-1:0] LD_PWR = CNT_W'(POWERON_CYC - 2);
  localparam logic [CNT_W-1:0] LD_E   = CNT_W'(E_PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] LD_CMD = CNT_W'(CMD_WAIT_CYC - 1);
  localparam logic [CNT_W-1:0] LD_CLR = CNT_W'(CLEAR_WAIT_CYC - 1);

  byte_phase_e      phase_q, phase_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rs_q, rs_d, e_q, e_d, long_q, long_d;
  logic [7:0]       data_q, data_d;
  logic             go_fetch;

  // Done on the last delay/hold cycle lets the next byte start with no gap.
  assign done_o = (phase_q == PH_DELAY || phase_q == PH_HOLD) && cnt_q == '0;
  assign rs_o   = rs_q;
  assign e_o    = e_q;
  assign data_o = data_q;

  // Phase sequencing; commands load the bus at FETCH entry, data at FETCH exit.
  always_comb begin
    phase_d  = phase_q;
    cnt_d    = cnt_q;
    rs_d     = rs_q;
    e_d      = e_q;
    long_d   = long_q;
    data_d   = data_q;
    go_fetch = 1'b0;
    case (phase_q)
      PH_IDLE: begin
        if (pwron_i) begin
          phase_d = PH_DELAY;
          cnt_d   = LD_PWR;
        end else if (start_i) begin
          go_fetch = 1'b1;
        end
      end
      PH_DELAY, PH_HOLD: begin
        if (cnt_q != '0)  cnt_d    = cnt_q - 1'b1;
        else if (start_i) go_fetch = 1'b1;
        else              phase_d  = PH_IDLE;
      end
      PH_FETCH: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          if (rs_q) data_d = printable(char_i);
          e_d     = 1'b1;
          cnt_d   = LD_E;
          phase_d = PH_STROBE;
        end
      end
      PH_STROBE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          e_d     = 1'b0;
          cnt_d   = long_q ? LD_CLR : LD_CMD;
          phase_d = PH_HOLD;
        end
      end
      default: phase_d = PH_IDLE;
    endcase
    if (go_fetch) begin
      phase_d = PH_FETCH;
      cnt_d   = CNT_W'(1);
      rs_d    = is_data_i;
      long_d  = long_wait_i;
      if (!is_data_i) data_d = byte_i;
    end
  end

  // Phase, counter and bus registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      phase_q <= PH_IDLE;
      cnt_q   <= '0;
      rs_q    <= 1'b0;
      e_q     <= 1'b0;
      long_q  <= 1'b0;
      data_q  <= 8'h00;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      rs_q    <= rs_d;
      e_q     <= e_d;
      long_q  <= long_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/lcd_text_driver.sv
// Power-on init then endless refresh of a 32-character frame onto a 16x2 LCD.
module lcd_text_driver
  import lcd_pkg::*;
#(
  parameter int POWERON_CYC    = 750000,
  parameter int E_PULSE_CYC    = 25,
  parameter int CMD_WAIT_CYC   = 2500,
  parameter int CLEAR_WAIT_CYC = 100000
) (
  input  logic       clk,
  input  logic       rst,
  output logic [4:0] index,
  input  logic [7:0] char_in,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic [7:0] lcd_data,
  output logic       init_done,
  output logic       frame_done
);

  top_state_e st_q, st_d;
  logic [1:0] step_q, step_d;
  logic [4:0] idx_q, idx_d;
  logic       init_q, init_d, frame_q, frame_d;
  logic       wr_done, wr_start, wr_data, wr_long, wr_pwron;
  logic [7:0] wr_byte;

  assign index      = idx_q;
  assign lcd_rw     = 1'b0;
  assign init_done  = init_q;
  assign frame_done = frame_q;

  lcd_byte_writer #(
    .POWERON_CYC   (POWERON_CYC),
    .E_PULSE_CYC   (E_PULSE_CYC),
    .CMD_WAIT_CYC  (CMD_WAIT_CYC),
    .CLEAR_WAIT_CYC(CLEAR_WAIT_CYC)
  ) u_wr (
    .clk_i      (clk),
    .rst_ni     (rst),
    .pwron_i    (wr_pwron),
    .start_i    (wr_start),
    .is_data_i  (wr_data),
    .long_wait_i(wr_long),
    .byte_i     (wr_byte),
    .char_i     (char_in),
    .done_o     (wr_done),
    .rs_o       (lcd_rs),
    .e_o        (lcd_e),
    .data_o     (lcd_data)
  );

  // On each writer done, pick the next byte and launch it in the same cycle;
  // index moves together with the data FETCH entry.
  always_comb begin
    st_d     = st_q;
    step_d   = step_q;
    idx_d    = idx_q;
    init_d   = init_q;
    frame_d  = 1'b0;
    wr_start = 1'b0;
    wr_data  = 1'b0;
    wr_long  = 1'b0;
    wr_byte  = 8'h00;
    wr_pwron = (st_q == ST_PWRON);
    if (wr_done) begin
      wr_start = 1'b1;
      case (st_q)
        ST_PWRON: begin
          st_d    = ST_INIT;
          step_d  = 2'd0;
          wr_byte = CMD_FUNC;
        end
        ST_INIT: begin
          if (step_q == 2'd3) begin
            st_d    = ST_ADDR1;
            init_d  = 1'b1;
            wr_byte = CMD_LINE1;
          end else begin
            step_d  = step_q + 2'd1;
            wr_byte = init_cmd(step_d);
            wr_long = (step_d == 2'd3);
          end
        end
        ST_ADDR1: begin
          st_d    = ST_LINE1;
          idx_d   = 5'd0;
          wr_data = 1'b1;
        end
        ST_LINE1: begin
          if (idx_q == 5'd15) begin
            st_d    = ST_ADDR2;
            wr_byte = CMD_LINE2;
          end else begin
            idx_d   = idx_q + 5'd1;
            wr_data = 1'b1;
          end
        end
        ST_ADDR2: begin
          st_d    = ST_LINE2;
          idx_d   = 5'd16;
          wr_data = 1'b1;
        end
        ST_LINE2: begin
          if (idx_q == 5'd31) begin
            st_d    = ST_ADDR1;
            frame_d = 1'b1;
            wr_byte = CMD_LINE1;
          end else begin
            idx_d   = idx_q + 5'd1;
            wr_data = 1'b1;
          end
        end
        default: begin
          st_d     = ST_PWRON;
          wr_start = 1'b0;
        end
      endcase
    end
  end

  // Top sequencer registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q    <= ST_PWRON;
      step_q  <= 2'd0;
      idx_q   <= 5'd0;
      init_q  <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      st_q    <= st_d;
      step_q  <= step_d;
      idx_q   <= idx_d;
      init_q  <= init_d;
      frame_q <= frame_d;
    end
  end

endmodule

// File: tb/tb_lcd_text_driver.sv
// Bench for lcd_text_driver: byte-stream model plus per-cycle bus monitor.
module tb_lcd_text_driver;

  localparam int P = 20, E = 3, W = 5, C = 12;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] index;
  logic [7:0] char_in;
  logic       lcd_rs, lcd_rw, lcd_e, init_done, frame_done;
  logic [7:0] lcd_data;

  int nvec = 0, nfail = 0;
  int cyc, nbytes, fpulses, run;
  logic bad5;

  lcd_text_driver #(
    .POWERON_CYC(P), .E_PULSE_CYC(E), .CMD_WAIT_CYC(W), .CLEAR_WAIT_CYC(C)
  ) dut (
    .clk(clk), .rst(rst), .index(index), .char_in(char_in),
    .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e), .lcd_data(lcd_data),
    .init_done(init_done), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Registered character source: 'A' + index, optionally a control char at slot 5.
  always @(posedge clk) char_in <= (bad5 && index == 5'd5) ? 8'h07 : 8'h41 + {3'b000, index};

  always @(posedge clk or negedge rst)
    if (!rst) cyc <= 0; else cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  typedef struct packed {
    logic       rs;
    logic [7:0] d;
    logic       lng;
    logic       ischar;
    logic [4:0] idx;
  } exp_t;

  // Expected n-th byte on the bus since reset release.
  function automatic exp_t model(input int n, input int r);
    exp_t x;
    int m, f, c;
    x = '0;
    if (n < 4) begin
      case (n)
        0: x.d = 8'h38;
        1: x.d = 8'h0C;
        2: x.d = 8'h06;
        default: begin x.d = 8'h01; x.lng = 1'b1; end
      endcase
      return x;
    end
    m = (n - 4) % 34;
    f = (n - 4) / 34;
    if (m == 0)       x.d = 8'h80;
    else if (m == 17) x.d = 8'hC0;
    else begin
      c = (m < 17) ? m - 1 : m - 2;
      x.rs = 1'b1;
      x.ischar = 1'b1;
      x.idx = c[4:0];
      x.d = (f == 1 && r == 0 && c == 5) ? 8'h20 : 8'h41 + c[7:0];
    end
    return x;
  endfunction

  // Bus monitor: every cycle while out of reset.
  exp_t xe;
  logic first, prev_e, prev_fd, lat_rs;
  logic [7:0] lat_d;
  logic [4:0] idx_h1, idx_h2;
  int low_run, high_run, prev_wait;
  always @(negedge clk) begin
    if (!rst) begin
      nbytes = 0; fpulses = 0; first = 1; prev_e = 0; prev_fd = 0;
      low_run = 0; high_run = 0; prev_wait = 0; idx_h1 = 0; idx_h2 = 0;
    end else begin
      chk("rw_zero", lcd_rw, 0);
      if (lcd_e && !prev_e) begin
        xe = model(nbytes, run);
        if (first) chk("first_rise_cycle", cyc, P + 2);
        else       chk("low_gap", low_run, prev_wait + 2);
        chk("rs", lcd_rs, xe.rs);
        chk("data", lcd_data, xe.d);
        chk("init_done", init_done, nbytes >= 4);
        if (xe.ischar) begin
          chk("index", index, xe.idx);
          chk("index_hold1", idx_h1, xe.idx);
          chk("index_hold2", idx_h2, xe.idx);
        end
        lat_rs = lcd_rs; lat_d = lcd_data;
        prev_wait = xe.lng ? C : W;
        nbytes++; first = 0; high_run = 1;
      end else if (lcd_e) begin
        chk("rs_stable", lcd_rs, lat_rs);
        chk("data_stable", lcd_data, lat_d);
        high_run++;
      end
      if (!lcd_e && prev_e) chk("e_width", high_run, E);
      if (!lcd_e) low_run = prev_e ? 1 : low_run + 1;
      if (frame_done) begin
        chk("fd_single", prev_fd, 0);
        chk("fd_after_line2", (nbytes >= 38) && ((nbytes - 4) % 34 == 0), 1);
        if (!prev_fd) fpulses++;
      end
      prev_fd = frame_done;
      prev_e = lcd_e;
      idx_h2 = idx_h1; idx_h1 = index;
    end
  end

  int ok;
  initial begin
    bad5 = 0; run = 0;
    // pin the model with hand-derived bytes
    chk("model_n0", model(0, 0).d, 8'h38);
    chk("model_n3_long", {model(3, 0).lng, model(3, 0).d}, 9'h101);
    chk("model_n4", model(4, 0).d, 8'h80);
    chk("model_n5", {model(5, 0).rs, model(5, 0).d}, 9'h141);
    chk("model_n21", model(21, 0).d, 8'hC0);
    chk("model_n37", {model(37, 0).idx, model(37, 0).d}, {5'd31, 8'h60});
    chk("model_bad5", model(44, 0).d, 8'h20);

    repeat (3) @(negedge clk);
    chk("rst_index", index, 0);
    chk("rst_rs", lcd_rs, 0);
    chk("rst_rw", lcd_rw, 0);
    chk("rst_e", lcd_e, 0);
    chk("rst_data", lcd_data, 0);
    chk("rst_init", init_done, 0);
    chk("rst_frame", frame_done, 0);
    rst = 1'b1;

    // three full frames; slot 5 is a control character during frame 1
    ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      bad5 = (fpulses == 1);
      if (nbytes >= 4 + 3 * 34 + 1) begin ok = 1; break; end
    end
    bad5 = 0;
    chk("frames_timeout", ok, 1);
    chk("frame_pulses", fpulses, 3);

    // reset in the middle of a data strobe
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      if (lcd_e && lcd_rs) begin ok = 1; break; end
    end
    chk("data_strobe_seen", ok, 1);
    @(posedge clk); #1;
    rst = 1'b0; run = 1;
    #1;
    chk("mid_rst_e", lcd_e, 0);
    chk("mid_rst_init", init_done, 0);
    chk("mid_rst_index", index, 0);
    chk("mid_rst_rs", lcd_rs, 0);
    chk("mid_rst_data", lcd_data, 0);
    chk("mid_rst_frame", frame_done, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      if (nbytes >= 6) begin ok = 1; break; end
    end
    chk("restart_timeout", ok, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
